// File: rtl/params.sv
// Shared project defaults for the watchdog heartbeat transmitter.
package params;
    localparam int unsigned WATCHDOG_SIGNATURE_BITS    = 24;
    localparam logic [23:0] WATCHDOG_SIGNATURE_PATTERN = 24'hA5C3E1;
    localparam int unsigned WATCHDOG_CONTROL_TICKS     = 200;
endpackage

// File: rtl/watchdog_heartbeat_tx.sv
// Watchdog heartbeat transmitter: every HEARTBEAT_INTERVAL_TICKS cycles it
// sends a frame of WATCHDOG_CMD_BYTE followed by the signature (MSB first)
// over a valid/ready byte stream.
// Optional build macro WATCHDOG_HEARTBEAT_FORCE_EN adds a force_send input
// that requests a frame immediately, regardless of enable.
module watchdog_heartbeat_tx #(
    parameter int unsigned WATCHDOG_SIGNATURE_BITS = params::WATCHDOG_SIGNATURE_BITS,
    parameter logic [WATCHDOG_SIGNATURE_BITS-1:0] WATCHDOG_SIGNATURE_PATTERN =
        params::WATCHDOG_SIGNATURE_PATTERN,
    parameter logic [7:0] WATCHDOG_CMD_BYTE = 8'h57,
    parameter int unsigned HEARTBEAT_INTERVAL_TICKS = params::WATCHDOG_CONTROL_TICKS / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       tx_ready,
`ifdef WATCHDOG_HEARTBEAT_FORCE_EN
    input  logic       force_send,
`endif
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy,
    output logic       frame_sent
);

    localparam int unsigned SIGBYTES = WATCHDOG_SIGNATURE_BITS / 8;
    localparam int unsigned IDX_W    = (SIGBYTES > 1) ? $clog2(SIGBYTES) : 1;
    localparam int unsigned CNT_W    = $clog2(HEARTBEAT_INTERVAL_TICKS);
    localparam int unsigned SHIFT_W  = IDX_W + 3;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HEARTBEAT_INTERVAL_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(SIGBYTES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_CMD = 2'd1,
        SEND_SIG = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             busy_q, busy_d;
    logic             frame_sent_q, frame_sent_d;
    logic             pending_q, pending_d;

    logic             expire;
    logic             consume;
    logic             xfer;

    // Signature byte at a given index (index 0 is the LSB byte).
    function automatic logic [7:0] sig_byte(input logic [IDX_W-1:0] idx);
        logic [SHIFT_W-1:0] sh;
        sh = {idx, 3'b000};
        return 8'(WATCHDOG_SIGNATURE_PATTERN >> sh);
    endfunction

    assign xfer = tx_valid_q && tx_ready;

    // Interval counter and pending request bookkeeping.
    always_comb begin
        expire    = enable && (cnt_q == '0);
        cnt_d     = cnt_q - CNT_W'(1);
        pending_d = pending_q;
        if (!enable || expire) begin
            cnt_d = CNT_RELOAD;
        end
        if (consume) begin
            pending_d = 1'b0;
        end
        if (!enable) begin
            pending_d = 1'b0;
        end
        // An expiry on the consuming edge leaves a new request pending.
        if (expire) begin
            pending_d = 1'b1;
        end
`ifdef WATCHDOG_HEARTBEAT_FORCE_EN
        if (force_send) begin
            cnt_d     = CNT_RELOAD;
            pending_d = 1'b1;
        end
`endif
    end

    // Frame FSM next-state and registered-output next values.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        consume    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d    = SEND_CMD;
                    tx_valid_d = 1'b1;
                    tx_data_d  = WATCHDOG_CMD_BYTE;
                    idx_d      = IDX_LAST;
                    consume    = 1'b1;
                end
            end
            SEND_CMD: begin
                if (xfer) begin
                    state_d   = SEND_SIG;
                    idx_d     = IDX_LAST;
                    tx_data_d = sig_byte(IDX_LAST);
                end
            end
            SEND_SIG: begin
                if (xfer) begin
                    if (idx_q == '0) begin
                        state_d    = DONE;
                        tx_valid_d = 1'b0;
                        idx_d      = IDX_LAST;
                    end else begin
                        idx_d     = idx_q - IDX_W'(1);
                        tx_data_d = sig_byte(idx_q - IDX_W'(1));
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d       = (state_d != IDLE);
        frame_sent_d = (state_d == DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= CNT_RELOAD;
            idx_q        <= IDX_LAST;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_sent_q <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            busy_q       <= busy_d;
            frame_sent_q <= frame_sent_d;
            pending_q    <= pending_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = busy_q;
    assign frame_sent = frame_sent_q;

endmodule

// File: tb/tb_watchdog_heartbeat_tx.sv
// Directed bench for watchdog_heartbeat_tx with default parameters
// (24-bit signature A5C3E1, command 57, interval 100).
module tb_watchdog_heartbeat_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       busy;
    logic       frame_sent;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fs_cnt   = 0;
    int stall_err = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic [7:0] cap_q[$];
    logic [7:0] exp_b[4] = '{8'h57, 8'hA5, 8'hC3, 8'hE1};

    watchdog_heartbeat_tx dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .busy       (busy),
        .frame_sent (frame_sent)
    );

    always #5 clk = ~clk;

    // Mid-cycle observer: captured transfers, frame_sent pulses, stall stability.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(tx_valid && tx_data == prev_data)) stall_err++;
            if (tx_valid && tx_ready) cap_q.push_back(tx_data);
            if (frame_sent) fs_cnt++;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        cyc = 0;
        fs_cnt = 0;
        stall_err = 0;
        cap_q.delete();
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!tx_valid && n <= max) begin
            step();
            n++;
        end
    endtask

    task automatic check_frame(input string tag, input int base);
        for (int i = 0; i < 4; i++) begin
            if (base + i < cap_q.size())
                check($sformatf("%s_b%0d", tag, i), 32'(cap_q[base+i]), 32'(exp_b[i]));
            else
                check($sformatf("%s_b%0d_missing", tag, i), 32'hDEAD, 32'(exp_b[i]));
        end
    endtask

    initial begin
        int n;
        int t_first;
        int vcount;
        reset    = 1'b1;
        enable   = 1'b1;
        tx_ready = 1'b1;

        // Reset values and nominal back-to-back frame.
        step();
        check("rst_valid", 32'(tx_valid), 0);
        check("rst_data", 32'(tx_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_fsent", 32'(frame_sent), 0);
        do_reset();
        wait_valid(300, n);
        check("t1_latency", n, 101);
        t_first = cyc;
        check("t1_cmd", 32'(tx_data), 32'h57);
        check("t1_busy", 32'(busy), 1);
        step();
        check("t1_sig2", 32'(tx_data), 32'hA5);
        step();
        check("t1_sig1", 32'(tx_data), 32'hC3);
        step();
        check("t1_sig0", 32'(tx_data), 32'hE1);
        check("t1_sig0_valid", 32'(tx_valid), 1);
        step();
        check("t1_done_valid", 32'(tx_valid), 0);
        check("t1_done_fsent", 32'(frame_sent), 1);
        check("t1_done_busy", 32'(busy), 1);
        step();
        check("t1_idle_fsent", 32'(frame_sent), 0);
        check("t1_idle_busy", 32'(busy), 0);
        wait_valid(300, n);
        check("t1_period", cyc - t_first, 100);
        check("t1_fsent_cnt", fs_cnt, 1);
        check("t1_cnt", cap_q.size(), 4);
        check_frame("t1", 0);

        // Ready toggling every cycle: stable data during stalls, no skip/dup.
        tx_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 400 && fs_cnt == 0; i++) begin
            tx_ready = ~tx_ready;
            step();
        end
        check("t2_fsent", fs_cnt, 1);
        check("t2_cnt", cap_q.size(), 4);
        check_frame("t2", 0);
        check("t2_stall_err", stall_err, 0);

        // Long stall: one frame, then the one pending request, then a fresh expiry.
        tx_ready = 1'b0;
        do_reset();
        run_to(250);
        check("t3_stall_valid", 32'(tx_valid), 1);
        check("t3_stall_data", 32'(tx_data), 32'h57);
        check("t3_stall_cnt", cap_q.size(), 0);
        tx_ready = 1'b1;
        run_to(262);
        check("t3_cnt", cap_q.size(), 8);
        check_frame("t3a", 0);
        check_frame("t3b", 4);
        check("t3_fsent", fs_cnt, 2);
        check("t3_idle_valid", 32'(tx_valid), 0);
        run_to(300);
        check("t3_quiet_cnt", cap_q.size(), 8);
        wait_valid(300, n);
        check("t3_fresh_cyc", cyc, 301);
        check("t3_fresh_data", 32'(tx_data), 32'h57);

        // Reset mid-frame after A5 transferred.
        tx_ready = 1'b1;
        do_reset();
        run_to(103);
        check("t4_pre_data", 32'(tx_data), 32'hC3);
        reset = 1'b1;
        step();
        check("t4_rst_valid", 32'(tx_valid), 0);
        check("t4_rst_busy", 32'(busy), 0);
        check("t4_rst_data", 32'(tx_data), 0);
        reset = 1'b0;
        cyc = 0;
        cap_q.delete();
        wait_valid(300, n);
        check("t4_latency", n, 101);
        check("t4_restart", 32'(tx_data), 32'h57);

        // Enable dropped mid-frame: frame finishes, pending cleared, then quiet.
        tx_ready = 1'b0;
        do_reset();
        run_to(210);
        check("t5_stall_valid", 32'(tx_valid), 1);
        enable = 1'b0;
        step();
        tx_ready = 1'b1;
        run_to(220);
        check("t5_cnt", cap_q.size(), 4);
        check_frame("t5", 0);
        check("t5_fsent", fs_cnt, 1);
        vcount = 0;
        for (int i = 0; i < 500; i++) begin
            step();
            if (tx_valid) vcount++;
        end
        check("t5_quiet_valid", vcount, 0);
        check("t5_quiet_cnt", cap_q.size(), 4);
        enable = 1'b1;
        wait_valid(300, n);
        check("t5_reenable_lat", n, 101);
        check("t5_reenable_data", 32'(tx_data), 32'h57);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
